keypad_entry_n: RTL and testbench
=================================

Name: keypad_entry_n

Overview:
- Parametrised successor to the microwave keypad encoder.
- Accepts NUM_KEYS active-low keys and debounces them.
- Priority-encodes the key, emits a one-cycle active-low load strobe, and shifts the accepted code into an NUM_DIGITS-deep digit register for the time-entry path.
- Also generates the 1 Hz countdown tick, muxed with the key-accept pulse by enablen.

Parameters:
- NUM_KEYS, 10: number of keypad lines; key index i maps to code i.
- NUM_DIGITS, 4: depth of the entered-digit shift register.
- DEBOUNCE_CYCLES, 7: consecutive stable cycles required for press and for release.
- DIV_CYCLES, 50000000: clk cycles per pgt_1hz tick in countdown mode.
- REPEAT_CYCLES, 25000000: auto-repeat period (optional feature only).
- Localparam CODE_W = clog2(NUM_KEYS), minimum 1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- clear  input  1  synchronous active-high reset.
- keypad  input  NUM_KEYS  active-low key lines; 0 = pressed.
- enablen  input  1  active-low entry enable; 0 = entry mode, 1 = countdown mode.
- D  output  CODE_W  code of last accepted key.
- digits  output  NUM_DIGITS*CODE_W  entered codes; newest in LSBs.
- loadn  output  1  low for exactly one cycle per accepted key.
- pgt_1hz  output  1  one-cycle high tick.

Behaviour:
- Reset (clear=1 at a clock edge), registered:
  - D=0, digits=0, loadn=1, pgt_1hz=0.
  - Divider and debounce counters 0; FSM to IDLE.
  - Clear has priority over every other event.
- Priority encode: cand = highest index i with keypad[i]=0. any = at least one key pressed. Multiple keys pressed: highest index wins.
- FSM states:
  - IDLE:
    - any=1 -> DEB_PRESS, latch cand into held, counter=1.
  - DEB_PRESS:
    - any=0 -> IDLE.
    - cand != held -> latch new cand, counter=1, stay.
    - Otherwise counter++.
    - When counter reaches DEBOUNCE_CYCLES -> ACCEPT.
  - ACCEPT (one cycle):
    - D <= held; loadn=0.
    - digits <= {digits[(NUM_DIGITS-1)*CODE_W-1:0], held}; oldest code discarded.
    - Counter=0 -> HELD.
  - HELD:
    - any=1 -> counter=0.
    - any=0 -> counter++; reaching DEBOUNCE_CYCLES -> IDLE.
    - A change of cand while held never generates a second accept.
- Latency: a key stable from cycle 0 produces loadn=0 at cycle DEBOUNCE_CYCLES+1 after first sample. D and digits update on that same edge.
- loadn is registered. It is 1 in every state except the ACCEPT cycle.
- enablen=1:
  - FSM forced to IDLE and counters cleared every cycle; keypad ignored; no accepts.
  - D and digits hold.
  - Deassertion mid-debounce aborts the press with no strobe.
- Divider:
  - Runs only while enablen=1, counting 0..DIV_CYCLES-1.
  - Terminal count gives pgt_1hz=1 for one cycle, then wraps to 0.
  - Cleared to 0 while enablen=0, so the first tick after enable comes DIV_CYCLES cycles later.
- pgt_1hz mux (registered):
  - enablen=1: divider tick.
  - enablen=0: pgt_1hz = ~loadn, i.e. coincident with the accept strobe.
- Widths: cand, held and D are CODE_W bits. No arithmetic beyond counters. Counters are sized to hold their maximum and never overflow.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - In HELD with any=1 and cand==held, a repeat counter increments.
  - On reaching REPEAT_CYCLES, the FSM goes to ACCEPT again with the same code and the repeat counter resets.
  - A different cand, or release, clears the repeat counter.
  - Release behaviour is unchanged.
- Undefined: repeat logic and REPEAT_CYCLES have no effect; one accept per press.

Test Plan (NUM_KEYS=10, NUM_DIGITS=4, DEBOUNCE_CYCLES=7, DIV_CYCLES=10):
- Reset: clear=1 for 2 cycles with keypad[5]=0 -> D=0, digits=0, loadn=1, pgt_1hz=0 throughout. No accept until 8 cycles after clear falls.
- Single press:
  - enablen=0, key 3 low for 20 cycles then released 10 cycles -> exactly one loadn=0 pulse at cycle 8.
  - D=3, digits=16'h0003, pgt_1hz high in the same cycle.
- Bounce: key 7 toggles every 3 cycles for 15 cycles, then steady 10 cycles -> single accept, 8 cycles after steady start, D=7.
- Priority and shift:
  - Keys 2 and 9 pressed together -> D=9.
  - Then keys 1, 2, 3, 4 entered -> digits=16'h1234; a fifth key 5 -> digits=16'h2345.
- Mode switch:
  - enablen=1 -> pgt_1hz pulses every 10 cycles.
  - Key presses produce no loadn.
  - enablen rises mid-debounce -> no strobe; D and digits unchanged.
- Auto-repeat (KEYPAD_AUTOREPEAT_EN, REPEAT_CYCLES=5): key 4 held 30 cycles -> accepts at cycle 8, then every 6 cycles (ACCEPT plus 5), each shifting 4 into digits.

Source files
------------

// File: rtl/keypad_entry_n.sv
// -----------------------------------------------------------------------------
// keypad_entry_n
// Parametrised keypad front end for the microwave time-entry path.
// NUM_KEYS active-low key lines are debounced and priority-encoded (highest
// pressed index wins). Each accepted key produces a one-cycle active-low load
// strobe and is shifted into an NUM_DIGITS-deep digit register. In countdown
// mode (enablen=1) the keypad is ignored and a divider produces the 1 Hz tick.
//
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-accept a key that stays
// held for REPEAT_CYCLES cycles. With the macro undefined there is exactly one
// accept per press.
//
// Ports:
//   clk      in   system clock, rising edge
//   clear    in   synchronous active-high reset
//   keypad   in   [NUM_KEYS-1:0] active-low key lines (0 = pressed)
//   enablen  in   0 = entry mode, 1 = countdown mode
//   D        out  [CODE_W-1:0] code of last accepted key
//   digits   out  [NUM_DIGITS*CODE_W-1:0] entered codes, newest in LSBs
//   loadn    out  low for exactly one cycle per accepted key
//   pgt_1hz  out  one-cycle high tick (divider tick or accept strobe)
// -----------------------------------------------------------------------------
module keypad_entry_n #(
   parameter  int NUM_KEYS        = 10,
   parameter  int NUM_DIGITS      = 4,
   parameter  int DEBOUNCE_CYCLES = 7,
   parameter  int DIV_CYCLES      = 50000000,
   parameter  int REPEAT_CYCLES   = 25000000,
   localparam int CODE_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
   input  logic                         clk,
   input  logic                         clear,
   input  logic [NUM_KEYS-1:0]          keypad,
   input  logic                         enablen,
   output logic [CODE_W-1:0]            D,
   output logic [NUM_DIGITS*CODE_W-1:0] digits,
   output logic                         loadn,
   output logic                         pgt_1hz
);

   localparam int DIG_W = NUM_DIGITS * CODE_W;
   localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DIV_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
   localparam int REP_W = $clog2(REPEAT_CYCLES + 1);

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam bit AUTOREPEAT = 1'b1;
`else
   // Constant-false enable: the repeat counter never leaves zero and folds away.
   localparam bit AUTOREPEAT = 1'b0;
`endif

   // Counters compare against "last" values so they never exceed their maximum.
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_CYCLES - 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DEB_PRESS = 2'd1,
      ACCEPT    = 2'd2,
      HELD      = 2'd3
   } state_t;

   // Returns {any, cand}: any pressed line, and the highest pressed index.
   function automatic logic [CODE_W:0] encode_keys(input logic [NUM_KEYS-1:0] lines);
      logic [CODE_W:0] res;
      res = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (!lines[i]) begin
            res = {1'b1, CODE_W'(i)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   state_t              state_r, state_next;
   logic [DEB_W-1:0]    cnt_r, cnt_next;
   logic [REP_W-1:0]    rep_r, rep_next;
   logic [DIV_W-1:0]    div_r, div_next;
   logic [CODE_W-1:0]   held_r, held_next;
   logic [CODE_W-1:0]   d_r, d_next;
   logic [DIG_W-1:0]    digits_r, digits_next;
   logic                loadn_r, loadn_next;
   logic                pgt_r, pgt_next;

   logic [CODE_W:0]     enc_s;
   logic                any_s;
   logic [CODE_W-1:0]   cand_s;
   logic                accept_s;
   logic                tick_s;

   assign enc_s  = encode_keys(keypad);
   assign any_s  = enc_s[CODE_W];
   assign cand_s = enc_s[CODE_W-1:0];

   // FSM state, debounce/repeat counters, held code and divider.
   always_ff @(posedge clk) begin
      if (clear) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         rep_r   <= '0;
         div_r   <= '0;
         held_r  <= '0;
      end else begin
         state_r <= state_next;
         cnt_r   <= cnt_next;
         rep_r   <= rep_next;
         div_r   <= div_next;
         held_r  <= held_next;
      end
   end

   // Next-state logic: debounce press, accept, debounce release, auto-repeat.
   always_comb begin
      state_next = state_r;
      cnt_next   = cnt_r;
      rep_next   = rep_r;
      held_next  = held_r;
      if (enablen) begin
         // Countdown mode aborts any entry in progress.
         state_next = IDLE;
         cnt_next   = '0;
         rep_next   = '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (any_s) begin
                  state_next = DEB_PRESS;
                  held_next  = cand_s;
                  cnt_next   = DEB_W'(1);
               end else begin
                  cnt_next   = '0;
               end
            end
            DEB_PRESS: begin
               if (!any_s) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else if (cand_s != held_r) begin
                  // A different key restarts the stability window.
                  held_next  = cand_s;
                  cnt_next   = DEB_W'(1);
               end else if (cnt_r >= DEB_LAST) begin
                  state_next = ACCEPT;
                  cnt_next   = '0;
               end else begin
                  cnt_next   = cnt_r + DEB_W'(1);
               end
            end
            ACCEPT: begin
               state_next = HELD;
               cnt_next   = '0;
               rep_next   = '0;
            end
            HELD: begin
               if (any_s) begin
                  cnt_next = '0;
                  if (AUTOREPEAT && (cand_s == held_r)) begin
                     if (rep_r >= REP_LAST) begin
                        state_next = ACCEPT;
                        rep_next   = '0;
                     end else begin
                        rep_next   = rep_r + REP_W'(1);
                     end
                  end else begin
                     rep_next = '0;
                  end
               end else begin
                  rep_next = '0;
                  if (cnt_r >= DEB_LAST) begin
                     state_next = IDLE;
                     cnt_next   = '0;
                  end else begin
                     cnt_next   = cnt_r + DEB_W'(1);
                  end
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
               rep_next   = '0;
            end
         endcase
      end
   end

   // Divider runs only in countdown mode; held at zero during entry mode.
   always_comb begin
      tick_s = 1'b0;
      if (enablen) begin
         if (div_r >= DIV_LAST) begin
            tick_s   = 1'b1;
            div_next = '0;
         end else begin
            div_next = div_r + DIV_W'(1);
         end
      end else begin
         div_next = '0;
      end
   end

   // Output logic: values the output registers take on the next edge.
   always_comb begin
      accept_s    = (!enablen) && (state_r == ACCEPT);
      loadn_next  = ~accept_s;
      pgt_next    = enablen ? tick_s : accept_s;
      if (accept_s) begin
         d_next      = held_r;
         digits_next = (digits_r << CODE_W) | DIG_W'(held_r);
      end else begin
         d_next      = d_r;
         digits_next = digits_r;
      end
   end

   // Registered outputs.
   always_ff @(posedge clk) begin
      if (clear) begin
         d_r      <= '0;
         digits_r <= '0;
         loadn_r  <= 1'b1;
         pgt_r    <= 1'b0;
      end else begin
         d_r      <= d_next;
         digits_r <= digits_next;
         loadn_r  <= loadn_next;
         pgt_r    <= pgt_next;
      end
   end

   assign D       = d_r;
   assign digits  = digits_r;
   assign loadn   = loadn_r;
   assign pgt_1hz = pgt_r;

endmodule

// File: tb/tb_keypad_entry_n.sv
// -----------------------------------------------------------------------------
// tb_keypad_entry_n
// Scoreboard bench for keypad_entry_n (NUM_KEYS=10, NUM_DIGITS=4,
// DEBOUNCE_CYCLES=7, DIV_CYCLES=10, REPEAT_CYCLES=5). Expected accepts and
// divider ticks are queued with their cycle when stimulus is applied; a
// negedge monitor pops and compares them when the DUT strobes.
// -----------------------------------------------------------------------------
module tb_keypad_entry_n;

   logic        clk;
   logic        clear;
   logic [9:0]  keypad;
   logic        enablen;
   logic [3:0]  D;
   logic [15:0] digits;
   logic        loadn;
   logic        pgt_1hz;

   keypad_entry_n #(
      .NUM_KEYS        (10),
      .NUM_DIGITS      (4),
      .DEBOUNCE_CYCLES (7),
      .DIV_CYCLES      (10),
      .REPEAT_CYCLES   (5)
   ) dut (
      .clk     (clk),
      .clear   (clear),
      .keypad  (keypad),
      .enablen (enablen),
      .D       (D),
      .digits  (digits),
      .loadn   (loadn),
      .pgt_1hz (pgt_1hz)
   );

   localparam logic [9:0] NO_KEYS = 10'h3FF;

   typedef struct {
      int          cyc;
      logic [3:0]  code;
      logic [15:0] digs;
   } acc_t;

   acc_t acc_q[$];
   int   tick_q[$];
   acc_t mon_e;
   int   mon_t;

   int          cyc;
   int          n_checks;
   int          n_fail;
   logic        mon_en;
   logic [15:0] exp_digits;
   logic [3:0]  exp_d;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used to timestamp expectations.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Queue an accept of 'code' at cycle 'at', advancing the digit model.
   task automatic expect_accept(input logic [3:0] code, input int at);
      acc_t e;
      exp_digits = {exp_digits[11:0], code};
      exp_d      = code;
      e.cyc  = at;
      e.code = code;
      e.digs = exp_digits;
      acc_q.push_back(e);
   endtask

   task automatic drive_keys(input logic [9:0] pat, input int n);
      keypad = pat;
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [9:0] key_mask(input int k);
      logic [9:0] one;
      one = 10'd1;
      return ~(one << k);
   endfunction

   // Strobe monitor: every loadn pulse and every bare tick must be expected.
   always @(negedge clk) begin
      if (mon_en && !clear) begin
         if (loadn === 1'b0) begin
            if (acc_q.size() == 0) begin
               check_value("spurious_loadn", {63'd0, loadn}, 64'd1);
            end else begin
               mon_e = acc_q.pop_front();
               check_value("accept_cycle", cyc, mon_e.cyc);
               check_value("accept_D", {60'd0, D}, {60'd0, mon_e.code});
               check_value("accept_digits", {48'd0, digits}, {48'd0, mon_e.digs});
               check_value("accept_pgt", {63'd0, pgt_1hz}, 64'd1);
            end
         end else if (pgt_1hz === 1'b1) begin
            if (tick_q.size() == 0) begin
               check_value("spurious_tick", {63'd0, pgt_1hz}, 64'd0);
            end else begin
               mon_t = tick_q.pop_front();
               check_value("tick_cycle", cyc, mon_t);
            end
         end
      end
   end

   initial begin
      cyc        = 0;
      n_checks   = 0;
      n_fail     = 0;
      mon_en     = 1'b0;
      exp_digits = 16'h0000;
      exp_d      = 4'd0;
      clear      = 1'b1;
      enablen    = 1'b0;
      keypad     = key_mask(5);

      // Reset held for two edges with key 5 down: outputs stay at reset values.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_value("reset_D", {60'd0, D}, 64'd0);
         check_value("reset_digits", {48'd0, digits}, 64'd0);
         check_value("reset_loadn", {63'd0, loadn}, 64'd1);
         check_value("reset_pgt", {63'd0, pgt_1hz}, 64'd0);
      end
      mon_en = 1'b1;
      clear  = 1'b0;
      expect_accept(4'd5, cyc + 8);
      drive_keys(key_mask(5), 12);
      drive_keys(NO_KEYS, 10);

      // Clear wipes the accepted code and digits.
      clear = 1'b1;
      @(negedge clk);
      check_value("clear_D", {60'd0, D}, 64'd0);
      check_value("clear_digits", {48'd0, digits}, 64'd0);
      clear      = 1'b0;
      exp_digits = 16'h0000;
      exp_d      = 4'd0;
      @(negedge clk);

      // Single clean press of key 3.
      expect_accept(4'd3, cyc + 8);
      drive_keys(key_mask(3), 20);
      drive_keys(NO_KEYS, 10);
      check_value("single_digits", {48'd0, digits}, 64'h0003);

      // Key 7 bouncing every 3 cycles, then steady.
      for (int i = 0; i < 5; i++) begin
         drive_keys((i % 2 == 1) ? key_mask(7) : NO_KEYS, 3);
      end
      expect_accept(4'd7, cyc + 8);
      drive_keys(key_mask(7), 10);
      drive_keys(NO_KEYS, 10);

      // Keys 2 and 9 together: highest index wins.
      expect_accept(4'd9, cyc + 8);
      drive_keys(key_mask(2) & key_mask(9), 12);
      drive_keys(NO_KEYS, 10);

      // Digit entry 1,2,3,4 then 5 shifts the oldest out.
      for (int k = 1; k <= 5; k++) begin
         expect_accept(4'(k), cyc + 8);
         drive_keys(key_mask(k), 10);
         drive_keys(NO_KEYS, 10);
         if (k == 4) check_value("digits_1234", {48'd0, digits}, 64'h1234);
      end
      check_value("digits_2345", {48'd0, digits}, 64'h2345);

      // Changing the pressed key while held does not re-accept.
      expect_accept(4'd3, cyc + 8);
      drive_keys(key_mask(3), 10);
      drive_keys(key_mask(3) & key_mask(9), 10);
      drive_keys(NO_KEYS, 10);

      // Long hold of key 4: one accept, or a repeat every 6 cycles.
      expect_accept(4'd4, cyc + 8);
`ifdef KEYPAD_AUTOREPEAT_EN
      expect_accept(4'd4, cyc + 14);
      expect_accept(4'd4, cyc + 20);
      expect_accept(4'd4, cyc + 26);
`endif
      drive_keys(key_mask(4), 30);
      drive_keys(NO_KEYS, 10);

      // Countdown mode: ticks every 10 cycles, keys ignored.
      enablen = 1'b1;
      tick_q.push_back(cyc + 10);
      tick_q.push_back(cyc + 20);
      tick_q.push_back(cyc + 30);
      drive_keys(key_mask(6), 20);
      drive_keys(NO_KEYS, 15);
      enablen = 1'b0;
      drive_keys(NO_KEYS, 3);

      // Entering countdown mid-debounce aborts the press silently.
      drive_keys(key_mask(8), 4);
      enablen = 1'b1;
      drive_keys(key_mask(8), 4);
      drive_keys(NO_KEYS, 3);
      enablen = 1'b0;
      drive_keys(NO_KEYS, 10);
      check_value("abort_D", {60'd0, D}, {60'd0, exp_d});
      check_value("abort_digits", {48'd0, digits}, {48'd0, exp_digits});

      // Entry resumes normally; key 0 exercises the lowest code.
      expect_accept(4'd0, cyc + 8);
      drive_keys(key_mask(0), 10);
      drive_keys(NO_KEYS, 20);

      check_value("accepts_pending", acc_q.size(), 64'd0);
      check_value("ticks_pending", tick_q.size(), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
